// File: rtl/mpsoc_dbg_pkg.sv
// Shared definitions for the debug-unit Wishbone bridge blocks.
package mpsoc_dbg_pkg;

    // Bus-side controller states
    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } dbg_wb_state_e;

    // Classic single-cycle Wishbone transfer encodings
    localparam logic [2:0] WbCtiClassic = 3'b000;
    localparam logic [1:0] WbBteLinear  = 2'b00;

    // Default bus geometry
    localparam int unsigned DbgDefaultAw = 32;
    localparam int unsigned DbgDefaultDw = 32;

endpackage

// File: rtl/mpsoc_dbg_syncflop.sv
// Toggle-to-level synchroniser with a set/reset hold flop. A toggle on
// TOGGLE_IN is brought into DEST_CLK, edge-detected and latched into D_OUT,
// which stays high until D_RST. A new edge wins over a simultaneous D_RST so
// a toggle landing in the consume cycle is not lost.
module mpsoc_dbg_syncflop (
    input  logic DEST_CLK,
    input  logic RESET,
    input  logic TOGGLE_IN,
    input  logic D_SET,
    input  logic D_RST,
    output logic D_OUT
);

    logic sync1_q, sync2_q, syncprev_q;
    logic sr_q;
    logic edge_det;

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            syncprev_q <= 1'b0;
        end else begin
            sync1_q    <= TOGGLE_IN;
            sync2_q    <= sync1_q;
            syncprev_q <= sync2_q;
        end
    end

    assign edge_det = sync2_q ^ syncprev_q;

    // Hold flop: set has priority over clear
    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            sr_q <= 1'b0;
        end else if (edge_det || D_SET) begin
            sr_q <= 1'b1;
        end else if (D_RST) begin
            sr_q <= 1'b0;
        end
    end

    assign D_OUT = sr_q;

endmodule

// File: rtl/mpsoc_dbg_wb_sync_ctrl.sv
// Debug-domain request to Wishbone single-transfer controller. A toggle from
// the debug clock domain launches one classic Wishbone cycle; completion
// (ack, error or timeout) is reported back with a toggle on ACK_TOGGLE_OUT.
module mpsoc_dbg_wb_sync_ctrl
    import mpsoc_dbg_pkg::*;
#(
    parameter int unsigned AW      = DbgDefaultAw,
    parameter int unsigned DW      = DbgDefaultDw,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RSTN,

    input  logic            REQ_TOGGLE_IN,
    input  logic [AW-1:0]   ADDR_IN,
    input  logic [DW-1:0]   DATA_IN,
    input  logic [DW/8-1:0] SEL_IN,
    input  logic            WE_IN,

    output logic            ACK_TOGGLE_OUT,
    output logic [DW-1:0]   DATA_OUT,
    output logic            ERR_OUT,
    output logic            TIMEOUT_OUT,
    output logic            BUSY_OUT,

    output logic            WB_CYC_O,
    output logic            WB_STB_O,
    output logic            WB_WE_O,
    output logic [AW-1:0]   WB_ADR_O,
    output logic [DW-1:0]   WB_DAT_O,
    output logic [DW/8-1:0] WB_SEL_O,
    output logic [2:0]      WB_CTI_O,
    output logic [1:0]      WB_BTE_O,
    input  logic [DW-1:0]   WB_DAT_I,
    input  logic            WB_ACK_I,
    input  logic            WB_ERR_I
);

    // Counter is sized for TIMEOUT itself; keep at least one bit when disabled
    localparam int unsigned    CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

    dbg_wb_state_e    state_q;
    logic [AW-1:0]    adr_q;
    logic [DW-1:0]    wdat_q;
    logic [DW/8-1:0]  sel_q;
    logic             we_q;
    logic [CntW-1:0]  cnt_q;
    logic             ack_tgl_q;
    logic [DW-1:0]    rdat_q;
    logic             err_q;
    logic             tmo_q;

    logic             pending;
    logic             consume;
    logic             in_bus;
    logic             tmo_hit;
    logic             sync_rst;

    assign sync_rst = ~RSTN;
    assign consume  = (state_q == StIdle) && pending;

    mpsoc_dbg_syncflop u_req_sync (
        .DEST_CLK  (CLK),
        .RESET     (sync_rst),
        .TOGGLE_IN (REQ_TOGGLE_IN),
        .D_SET     (1'b0),
        .D_RST     (consume),
        .D_OUT     (pending)
    );

    // Last permitted wait cycle reached with no slave response
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TmoLast);

    // Controller FSM with its captured request fields and result registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= StIdle;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            ack_tgl_q <= 1'b0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pending) begin
                        adr_q   <= ADDR_IN;
                        wdat_q  <= DATA_IN;
                        sel_q   <= SEL_IN;
                        we_q    <= WE_IN;
                        cnt_q   <= '0;
                        state_q <= StBus;
                    end
                end
                StBus: begin
                    // Slave responses take priority over the timeout abort
                    if (WB_ERR_I) begin
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b0;
                        state_q <= StDone;
                    end else if (WB_ACK_I) begin
                        if (!we_q) begin
                            rdat_q <= WB_DAT_I;
                        end
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        state_q <= StDone;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    ack_tgl_q <= ~ack_tgl_q;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bus outputs are driven only while a cycle is open; reset drops them at once
    assign in_bus   = (state_q == StBus);
    assign WB_CYC_O = in_bus;
    assign WB_STB_O = in_bus;
    assign WB_WE_O  = in_bus & we_q;
    assign WB_ADR_O = in_bus ? adr_q  : '0;
    assign WB_DAT_O = in_bus ? wdat_q : '0;
    assign WB_SEL_O = in_bus ? sel_q  : '0;
    assign WB_CTI_O = in_bus ? WbCtiClassic : 3'b000;
    assign WB_BTE_O = in_bus ? WbBteLinear  : 2'b00;

    assign ACK_TOGGLE_OUT = ack_tgl_q;
    assign DATA_OUT       = rdat_q;
    assign ERR_OUT        = err_q;
    assign TIMEOUT_OUT    = tmo_q;
    assign BUSY_OUT       = (state_q != StIdle);

endmodule

// File: tb/tb_mpsoc_dbg_wb_sync_ctrl.sv
// Bench for the debug Wishbone sync controller: directed requests, a simple
// Wishbone slave model and a completion scoreboard keyed on ACK toggles.
module tb_mpsoc_dbg_wb_sync_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        REQ_TOGGLE_IN;
    logic [31:0] ADDR_IN;
    logic [31:0] DATA_IN;
    logic [3:0]  SEL_IN;
    logic        WE_IN;
    logic        ACK_TOGGLE_OUT;
    logic [31:0] DATA_OUT;
    logic        ERR_OUT;
    logic        TIMEOUT_OUT;
    logic        BUSY_OUT;
    logic        WB_CYC_O;
    logic        WB_STB_O;
    logic        WB_WE_O;
    logic [31:0] WB_ADR_O;
    logic [31:0] WB_DAT_O;
    logic [3:0]  WB_SEL_O;
    logic [2:0]  WB_CTI_O;
    logic [1:0]  WB_BTE_O;
    logic [31:0] WB_DAT_I;
    logic        WB_ACK_I;
    logic        WB_ERR_I;

    mpsoc_dbg_wb_sync_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .REQ_TOGGLE_IN  (REQ_TOGGLE_IN),
        .ADDR_IN        (ADDR_IN),
        .DATA_IN        (DATA_IN),
        .SEL_IN         (SEL_IN),
        .WE_IN          (WE_IN),
        .ACK_TOGGLE_OUT (ACK_TOGGLE_OUT),
        .DATA_OUT       (DATA_OUT),
        .ERR_OUT        (ERR_OUT),
        .TIMEOUT_OUT    (TIMEOUT_OUT),
        .BUSY_OUT       (BUSY_OUT),
        .WB_CYC_O       (WB_CYC_O),
        .WB_STB_O       (WB_STB_O),
        .WB_WE_O        (WB_WE_O),
        .WB_ADR_O       (WB_ADR_O),
        .WB_DAT_O       (WB_DAT_O),
        .WB_SEL_O       (WB_SEL_O),
        .WB_CTI_O       (WB_CTI_O),
        .WB_BTE_O       (WB_BTE_O),
        .WB_DAT_I       (WB_DAT_I),
        .WB_ACK_I       (WB_ACK_I),
        .WB_ERR_I       (WB_ERR_I)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        tmo;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Slave behaviour for the current transaction: ack_at = 0 means silent
    int          s_ack_at;
    logic        s_err;
    logic [31:0] s_dat;
    int          bus_n;
    int          last_len;
    logic        exp_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e, input logic t, input int l);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.tmo  = t;
        x.len  = l;
        exp_q.push_back(x);
    endtask

    task automatic toggle_req();
        @(negedge CLK);
        REQ_TOGGLE_IN = ~REQ_TOGGLE_IN;
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (WB_CYC_O !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(name, {31'b0, WB_CYC_O}, 32'd1);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        exp_ack = ~exp_ack;
        while (ACK_TOGGLE_OUT !== exp_ack && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(name, {31'b0, ACK_TOGGLE_OUT}, {31'b0, exp_ack});
    endtask

    // Wishbone slave: counts open bus cycles and responds on the chosen one
    initial begin
        WB_ACK_I = 1'b0;
        WB_ERR_I = 1'b0;
        WB_DAT_I = '0;
        bus_n    = 0;
        last_len = 0;
        forever begin
            @(negedge CLK);
            if (WB_CYC_O && WB_STB_O) begin
                bus_n = bus_n + 1;
                if (s_ack_at != 0 && bus_n == s_ack_at) begin
                    WB_ACK_I = 1'b1;
                    WB_ERR_I = s_err;
                    WB_DAT_I = s_dat;
                end else begin
                    WB_ACK_I = 1'b0;
                    WB_ERR_I = 1'b0;
                    WB_DAT_I = '0;
                end
            end else begin
                if (bus_n != 0) last_len = bus_n;
                bus_n    = 0;
                WB_ACK_I = 1'b0;
                WB_ERR_I = 1'b0;
                WB_DAT_I = '0;
            end
        end
    end

    // Monitor: every ACK toggle retires one expected completion
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RSTN !== 1'b1) begin
                prev = ACK_TOGGLE_OUT;
            end else if (ACK_TOGGLE_OUT !== prev) begin
                prev = ACK_TOGGLE_OUT;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack actual=toggle required=none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", DATA_OUT, mon_e.data);
                    chk("err_out", {31'b0, ERR_OUT}, {31'b0, mon_e.err});
                    chk("timeout_out", {31'b0, TIMEOUT_OUT}, {31'b0, mon_e.tmo});
                    chk("cyc_len", 32'(last_len), 32'(mon_e.len));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw_cyc;
        RSTN          = 1'b0;
        REQ_TOGGLE_IN = 1'b0;
        ADDR_IN       = '0;
        DATA_IN       = '0;
        SEL_IN        = '0;
        WE_IN         = 1'b0;
        s_ack_at      = 0;
        s_err         = 1'b0;
        s_dat         = '0;
        exp_ack       = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ack_toggle", {31'b0, ACK_TOGGLE_OUT}, 32'd0);
        chk("rst_data_out", DATA_OUT, 32'd0);
        chk("rst_err_tmo", {30'b0, ERR_OUT, TIMEOUT_OUT}, 32'd0);
        chk("rst_busy", {31'b0, BUSY_OUT}, 32'd0);
        chk("rst_wb_ctl", {29'b0, WB_CYC_O, WB_STB_O, WB_WE_O}, 32'd0);
        chk("rst_wb_adr", WB_ADR_O, 32'd0);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // Read, with the toggle-to-cycle latency measured edge by edge
        ADDR_IN = 32'h0000_1000; WE_IN = 1'b0; SEL_IN = 4'hF;
        s_ack_at = 3; s_err = 1'b0; s_dat = 32'hDEAD_BEEF;
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 3);
        toggle_req();
        repeat (3) @(posedge CLK);
        #1 chk("lat_cyc_low_n2", {31'b0, WB_CYC_O}, 32'd0);
        @(posedge CLK);
        #1 chk("lat_cyc_high_n3", {31'b0, WB_CYC_O}, 32'd1);
        chk("rd_adr", WB_ADR_O, 32'h0000_1000);
        chk("rd_we_stb", {30'b0, WB_WE_O, WB_STB_O}, 32'd1);
        chk("rd_cti_bte", {27'b0, WB_CTI_O, WB_BTE_O}, 32'd0);
        chk("rd_busy", {31'b0, BUSY_OUT}, 32'd1);
        wait_ack("rd_ack_toggle");
        repeat (2) @(negedge CLK);
        chk("rd_idle", {30'b0, BUSY_OUT, WB_CYC_O}, 32'd0);

        // Write: read data register must not change
        ADDR_IN = 32'h0000_2000; DATA_IN = 32'h1234_5678; SEL_IN = 4'hF; WE_IN = 1'b1;
        s_ack_at = 2; s_dat = 32'hCAFE_F00D;
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 2);
        toggle_req();
        wait_cyc("wr_cyc_seen");
        chk("wr_dat_o", WB_DAT_O, 32'h1234_5678);
        chk("wr_we_sel", {27'b0, WB_WE_O, WB_SEL_O}, 32'h1F);
        chk("wr_adr", WB_ADR_O, 32'h0000_2000);
        wait_ack("wr_ack_toggle");
        repeat (2) @(negedge CLK);

        // Error together with ack: error wins, data unchanged
        ADDR_IN = 32'h0000_0010; WE_IN = 1'b0; SEL_IN = 4'h3;
        s_ack_at = 1; s_err = 1'b1; s_dat = 32'h5555_5555;
        push_exp(32'hDEAD_BEEF, 1'b1, 1'b0, 1);
        toggle_req();
        wait_ack("err_ack_toggle");
        repeat (3) @(negedge CLK);
        chk("err_single_toggle", {31'b0, ACK_TOGGLE_OUT}, {31'b0, exp_ack});

        // Silent slave: abort after exactly TIMEOUT bus cycles
        s_ack_at = 0; s_err = 1'b0;
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b1, 4);
        toggle_req();
        wait_ack("tmo_ack_toggle");
        repeat (2) @(negedge CLK);

        // Ack on the last permitted cycle beats the timeout
        s_ack_at = 4; s_dat = 32'hA5A5_A5A5;
        push_exp(32'hA5A5_A5A5, 1'b0, 1'b0, 4);
        toggle_req();
        wait_ack("ack4_ack_toggle");
        repeat (2) @(negedge CLK);

        // Back-to-back: second toggle while the first is on the bus
        ADDR_IN = 32'h0000_2222;
        s_ack_at = 3; s_dat = 32'h0BAD_F00D;
        push_exp(32'h0BAD_F00D, 1'b0, 1'b0, 3);
        push_exp(32'h0BAD_F00D, 1'b0, 1'b0, 3);
        toggle_req();
        wait_cyc("b2b_cyc1_seen");
        @(negedge CLK);
        ADDR_IN = 32'h0000_3000;
        REQ_TOGGLE_IN = ~REQ_TOGGLE_IN;
        wait_ack("b2b_ack1_toggle");
        wait_cyc("b2b_cyc2_seen");
        chk("b2b_adr2", WB_ADR_O, 32'h0000_3000);
        wait_ack("b2b_ack2_toggle");
        repeat (4) @(negedge CLK);
        chk("b2b_idle", {31'b0, BUSY_OUT}, 32'd0);

        // Reset in the middle of a bus cycle
        s_ack_at = 0;
        toggle_req();
        wait_cyc("rstbus_cyc_seen");
        @(negedge CLK);
        RSTN = 1'b0;
        REQ_TOGGLE_IN = 1'b0;
        #1;
        chk("rstbus_cyc_drop", {30'b0, WB_CYC_O, WB_STB_O}, 32'd0);
        chk("rstbus_busy", {31'b0, BUSY_OUT}, 32'd0);
        chk("rstbus_ack_toggle", {31'b0, ACK_TOGGLE_OUT}, 32'd0);
        chk("rstbus_results", {DATA_OUT[29:0], ERR_OUT, TIMEOUT_OUT}, 32'd0);
        exp_ack = 1'b0;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        saw_cyc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (WB_CYC_O === 1'b1 || BUSY_OUT === 1'b1) saw_cyc = 1'b1;
        end
        chk("rstbus_no_txn", {31'b0, saw_cyc}, 32'd0);
        chk("rstbus_ack_still0", {31'b0, ACK_TOGGLE_OUT}, 32'd0);

        // Normal operation after reset
        ADDR_IN = 32'h0000_4000; WE_IN = 1'b0;
        s_ack_at = 1; s_dat = 32'h0F0F_0F0F;
        push_exp(32'h0F0F_0F0F, 1'b0, 1'b0, 1);
        toggle_req();
        wait_ack("post_rst_ack_toggle");
        repeat (3) @(negedge CLK);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
